// File: rtl/mar_arbiter_if.sv
// Request, MAR and memory-handshake bundle between the requesters/memory and mar_arbiter.
interface mar_arbiter_if #(
  parameter int unsigned AW = 15
);
  logic          req_f;
  logic [AW-1:0] addr_f;
  logic          req_d;
  logic [AW-1:0] addr_d;
  logic          we_d;
  logic          mem_ready;
  logic [AW-1:0] mar_addr;
  logic          mar_re;
  logic          mem_req;
  logic          mem_we;
  logic          ack_f;
  logic          ack_d;
  logic          err;
  logic          busy;
  logic          owner;

  // Requester/memory side.
  modport master (
    output req_f, addr_f, req_d, addr_d, we_d, mem_ready,
    input  mar_addr, mar_re, mem_req, mem_we, ack_f, ack_d, err, busy, owner
  );

  // Arbiter side.
  modport slave (
    input  req_f, addr_f, req_d, addr_d, we_d, mem_ready,
    output mar_addr, mar_re, mem_req, mem_we, ack_f, ack_d, err, busy, owner
  );
endinterface

// File: rtl/mar_arbiter.sv
// Fetch/data MAR arbiter and memory-handshake sequencer with bounded wait.
// Define MAR_ARB_RR_EN for round-robin tie breaking; default is fixed fetch priority.
module mar_arbiter #(
  parameter int unsigned AW       = 15,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic          clk,
  input logic          rst_n,
  mar_arbiter_if.slave bus
);

  localparam int unsigned   CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MEM  = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t        state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [AW-1:0] mar_addr_q, mar_addr_nx;
  logic          we_q, we_nx;
  logic          owner_q, owner_nx;
  logic          mar_re_q, mar_re_nx;
  logic          mem_req_q, mem_req_nx;
  logic          mem_we_q, mem_we_nx;
  logic          ack_f_q, ack_f_nx;
  logic          ack_d_q, ack_d_nx;
  logic          err_q, err_nx;
  logic          busy_q, busy_nx;

  logic          req_any_c;
  logic          pick_d_c;
  logic          timeout_c;

`ifdef MAR_ARB_RR_EN
  logic          last_d_q, last_d_nx;
`endif

  // Arbitration: who wins if a grant happens this cycle.
  always_comb begin
    req_any_c = bus.req_f | bus.req_d;
`ifdef MAR_ARB_RR_EN
    pick_d_c  = bus.req_d & (~bus.req_f | ~last_d_q);
`else
    pick_d_c  = bus.req_d & ~bus.req_f;
`endif
  end

  // Last allowed MEM cycle without ready ends the access with an error.
  always_comb begin
    timeout_c = (state_q == S_MEM) & ~bus.mem_ready & (cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (req_any_c) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_MEM;
      S_MEM:   if (bus.mem_ready || timeout_c) state_nx = S_ACK;
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output and datapath next values; pulses are decoded from the upcoming state.
  always_comb begin
    mar_addr_nx = mar_addr_q;
    owner_nx    = owner_q;
    we_nx       = we_q;
    cnt_nx      = cnt_q;
`ifdef MAR_ARB_RR_EN
    last_d_nx   = last_d_q;
`endif
    if ((state_q == S_IDLE) && req_any_c) begin
      mar_addr_nx = pick_d_c ? bus.addr_d : bus.addr_f;
      owner_nx    = pick_d_c;
      we_nx       = pick_d_c & bus.we_d;
      cnt_nx      = '0;
`ifdef MAR_ARB_RR_EN
      last_d_nx   = pick_d_c;
`endif
    end else if ((state_q == S_MEM) && !bus.mem_ready && !timeout_c) begin
      cnt_nx = cnt_q + CW'(1);
    end
    mar_re_nx  = (state_nx == S_LOAD);
    mem_req_nx = (state_nx == S_MEM);
    mem_we_nx  = (state_nx == S_MEM) & we_q;
    ack_f_nx   = (state_nx == S_ACK) & ~owner_q;
    ack_d_nx   = (state_nx == S_ACK) & owner_q;
    err_nx     = timeout_c;
    busy_nx    = (state_nx != S_IDLE);
  end

  // Registered outputs and transaction context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      mar_addr_q <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      mar_re_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      ack_f_q    <= 1'b0;
      ack_d_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_nx;
      mar_addr_q <= mar_addr_nx;
      we_q       <= we_nx;
      owner_q    <= owner_nx;
      mar_re_q   <= mar_re_nx;
      mem_req_q  <= mem_req_nx;
      mem_we_q   <= mem_we_nx;
      ack_f_q    <= ack_f_nx;
      ack_d_q    <= ack_d_nx;
      err_q      <= err_nx;
      busy_q     <= busy_nx;
    end
  end

`ifdef MAR_ARB_RR_EN
  // Resetting to data lets fetch win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_nx;
    end
  end
`endif

  assign bus.mar_addr = mar_addr_q;
  assign bus.mar_re   = mar_re_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.ack_f    = ack_f_q;
  assign bus.ack_d    = ack_d_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_mar_arbiter.sv
// Randomized scoreboard bench for mar_arbiter: driver predicts grant order, monitor checks each transaction.
module tb_mar_arbiter;

  localparam int unsigned AW = 15;
  localparam int          WM = 15;

  typedef struct {
    bit            owner;
    logic [AW-1:0] addr;
    bit            we;
    bit            err;
    int            mcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  mar_arbiter_if #(.AW(AW)) bus ();

  mar_arbiter #(.AW(AW), .WAIT_MAX(WM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   dly_q[$];
  bit   rr_last = 1'b1;

  logic [AW-1:0] fa [4];
  logic [AW-1:0] da [4];
  bit            dw [4];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pick_delay();
    case ($urandom_range(0, 6))
      0:       return 0;
      1:       return 1;
      2:       return int'($urandom_range(2, 5));
      3:       return WM - 2;
      4:       return WM - 1;
      5:       return WM;
      default: return WM + 3;
    endcase
  endfunction

  // Expected outcome of one access whose ready comes after d idle MEM cycles.
  task automatic push_exp(input bit owner, input logic [AW-1:0] addr, input bit we, input int d);
    exp_t e;
    e.owner = owner;
    e.addr  = addr;
    e.we    = we;
    e.err   = (d >= WM);
    e.mcyc  = e.err ? WM : d + 1;
    exp_q.push_back(e);
    dly_q.push_back(d);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4; i++) begin
      fa[i] = AW'($urandom);
      da[i] = AW'($urandom);
      dw[i] = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic int out_vec();
    return int'({bus.mar_addr, bus.mar_re, bus.mem_req, bus.mem_we, bus.ack_f,
                 bus.ack_d, bus.err, bus.busy, bus.owner});
  endfunction

  // Fetch wants nf accesses, data wants nd; both raise together and re-raise until served.
  task automatic run_round(input int nf, input int nd, input bit perturb, input int fd);
    int pf, pd, xf, xd, fi, di, cyc, d;
    bit take_d;
    pf = nf; pd = nd; xf = 0; xd = 0;
    while (pf > 0 || pd > 0) begin
`ifdef MAR_ARB_RR_EN
      take_d = (pd > 0) && (pf == 0 || rr_last == 1'b0);
`else
      take_d = (pd > 0) && (pf == 0);
`endif
      d = (fd >= 0) ? fd : pick_delay();
      if (take_d) begin
        push_exp(1'b1, da[xd], dw[xd], d);
        xd++; pd--; rr_last = 1'b1;
      end else begin
        push_exp(1'b0, fa[xf], 1'b0, d);
        xf++; pf--; rr_last = 1'b0;
      end
    end
    @(negedge clk);
    fi = 0; di = 0; cyc = 0;
    if (nf > 0) begin bus.addr_f = fa[0]; bus.req_f = 1'b1; end
    if (nd > 0) begin bus.addr_d = da[0]; bus.we_d = dw[0]; bus.req_d = 1'b1; end
    while ((fi < nf || di < nd) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("grant_latency", int'(bus.mar_re), 1);
      if (bus.ack_f) begin
        fi++;
        if (fi < nf) bus.addr_f = fa[fi]; else bus.req_f = 1'b0;
      end
      if (bus.ack_d) begin
        di++;
        if (di < nd) begin bus.addr_d = da[di]; bus.we_d = dw[di]; end
        else bus.req_d = 1'b0;
      end
      if (perturb && bus.mem_req) begin
        if (nd == 0) bus.addr_f = AW'($urandom);
        if (nf == 0) begin bus.addr_d = AW'($urandom); bus.we_d = 1'($urandom_range(0, 1)); end
      end
    end
    bus.req_f = 1'b0;
    bus.req_d = 1'b0;
    chk("round_complete", int'(fi >= nf && di >= nd), 1);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Memory model: ready after the planned number of MEM cycles; noise outside MEM.
  int k = 0;
  int cur_d = 0;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (k == 0) cur_d = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
      k++;
      bus.mem_ready = (k == cur_d + 1);
    end else begin
      k = 0;
      bus.mem_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: checks each grant, MEM phase and ack against the head of the queue.
  exp_t          cur;
  exp_t          got;
  bit            have_cur = 1'b0;
  int            mcyc = 0;
  bit            prev_re = 1'b0;
  bit            prev_mem = 1'b0;
  logic [AW-1:0] lat_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 1'b0; mcyc = 0; prev_re = 1'b0; prev_mem = 1'b0;
    end else begin
      chk("busy", int'(bus.busy), int'(bus.mar_re | bus.mem_req | bus.ack_f | bus.ack_d));
      if (bus.mar_re) begin
        chk("single_load", int'(prev_re), 0);
        chk("unexpected_grant", int'(exp_q.size() == 0), 0);
        mcyc = 0;
        lat_addr = bus.mar_addr;
        if (exp_q.size() > 0) begin
          cur = exp_q[0];
          have_cur = 1'b1;
          chk("grant_owner", int'(bus.owner), int'(cur.owner));
          chk("grant_addr", int'(bus.mar_addr), int'(cur.addr));
        end
      end
      if (bus.mem_req) begin
        mcyc++;
        if (mcyc == 1) chk("load_to_mem", int'(prev_re), 1);
        if (have_cur) chk("mem_we", int'(bus.mem_we), int'(cur.we));
        chk("addr_hold", int'(bus.mar_addr), int'(lat_addr));
      end else begin
        chk("mem_we_idle", int'(bus.mem_we), 0);
      end
      if (bus.ack_f || bus.ack_d) begin
        chk("ack_expected", int'(exp_q.size() == 0), 0);
        chk("ack_onehot", int'(bus.ack_f & bus.ack_d), 0);
        chk("mem_to_ack", int'(prev_mem), 1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          chk("ack_owner", int'(bus.ack_d), int'(got.owner));
          chk("ack_err", int'(bus.err), int'(got.err));
          chk("mem_cycles", mcyc, got.mcyc);
        end
        have_cur = 1'b0;
      end else begin
        chk("err_without_ack", int'(bus.err), 0);
      end
      prev_re  = bus.mar_re;
      prev_mem = bus.mem_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int seen;
    int nf, nd;
    rst_n = 1'b0;
    bus.req_f = 1'b0; bus.req_d = 1'b0; bus.we_d = 1'b0;
    bus.addr_f = '0;  bus.addr_d = '0;
    #1;
    chk("reset_outputs", out_vec(), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    fa[0] = 15'h1234;
    run_round(1, 0, 1'b0, 0);
    da[0] = 15'h7FFF; dw[0] = 1'b1;
    run_round(0, 1, 1'b0, 2);
    fill_random();
    run_round(3, 1, 1'b0, 0);
    fill_random();
    run_round(0, 1, 1'b0, WM + 3);
    fill_random();
    run_round(1, 0, 1'b0, WM - 1);
    fill_random();
    run_round(1, 0, 1'b1, 4);

    for (int r = 0; r < 60; r++) begin
      fill_random();
      nf = int'($urandom_range(0, 2));
      nd = int'($urandom_range(0, 2));
      if (nf == 0 && nd == 0) nf = 1;
      run_round(nf, nd, (nf == 0 || nd == 0), -1);
    end

    // Reset in the middle of a data access: nothing may be acknowledged.
    da[0] = 15'h5A5A; dw[0] = 1'b1;
    push_exp(1'b1, da[0], 1'b1, 100);
    @(negedge clk);
    bus.addr_d = da[0]; bus.we_d = 1'b1; bus.req_d = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen < 2; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen++;
    end
    chk("reached_mem", seen, 2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", out_vec(), 0);
    bus.req_d = 1'b0;
    exp_q.delete();
    dly_q.delete();
    rr_last = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    fa[0] = 15'h0ABC;
    run_round(1, 0, 1'b0, 1);

    for (int r = 0; r < 15; r++) begin
      fill_random();
      nf = int'($urandom_range(0, 2));
      nd = int'($urandom_range(0, 2));
      if (nf == 0 && nd == 0) nd = 1;
      run_round(nf, nd, 1'b0, -1);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
